// File: rtl/hex2ascii_pkg.sv
// Shared types and constants for the hex-to-ASCII UART transmitter.
// Optional CR/LF trailer is enabled by defining HEX2ASCII_CRLF_EN.
package hex2ascii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] HEX_ALPHA_OFS = 8'h37;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        logic [7:0] ext;
        ext = {4'h0, nib};
        return (nib < 4'd10) ? (ASCII_ZERO + ext) : (HEX_ALPHA_OFS + ext);
    endfunction

endpackage

// File: rtl/hex2ascii_baud_cnt.sv
// Bit-time counter: oTick marks the last cycle of every bit period.
// iClr restarts the period; the count also reloads to 0 on each tick.
module hex2ascii_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic iRst,
    input  logic iEn,
    input  logic iClr,
    output logic oTick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        oTick = 1'b0;
        if (iClr) begin
            cnt_d = '0;
        end else if (iEn) begin
            if (cnt_q == LAST) begin
                oTick = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (iRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hex2ascii_tx.sv
// Sends a hex nibble as one 8N1 ASCII character on a UART line.
// Define HEX2ASCII_CRLF_EN to append CR and LF frames to every character.
module hex2ascii_tx
    import hex2ascii_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       iRst,
    input  logic [3:0] iDigit,
    input  logic       iValid,
    output logic       oReady,
    output logic       oTx,
    output logic       oDone
);

    tx_state_e  state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       tx_q, tx_d;
    logic       tick;
    logic       baud_clr;
    logic       last_frame;
    logic       frame_end;
    logic [7:0] next_char;

`ifdef HEX2ASCII_CRLF_EN
    logic [1:0] chr_q, chr_d;

    assign last_frame = (chr_q == 2'd2);
    assign next_char  = (chr_q == 2'd0) ? ASCII_CR : ASCII_LF;
`else
    assign last_frame = 1'b1;
    assign next_char  = 8'h00;
`endif

    hex2ascii_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .iRst (iRst),
        .iEn  (state_q != ST_IDLE),
        .iClr (baud_clr),
        .oTick(tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        baud_clr  = 1'b0;
        frame_end = 1'b0;
`ifdef HEX2ASCII_CRLF_EN
        chr_d     = chr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    state_d  = ST_START;
                    shift_d  = hex_to_ascii(iDigit);
                    baud_clr = 1'b1;
`ifdef HEX2ASCII_CRLF_EN
                    chr_d    = 2'd0;
`endif
                end
            end
            ST_START: begin
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (!last_frame) begin
                        state_d = ST_START;
                        shift_d = next_char;
`ifdef HEX2ASCII_CRLF_EN
                        chr_d   = chr_q + 2'd1;
`endif
                    end else begin
                        // Ready is raised this cycle, so a waiting request starts at once.
                        frame_end = 1'b1;
                        if (iValid) begin
                            state_d = ST_START;
                            shift_d = hex_to_ascii(iDigit);
`ifdef HEX2ASCII_CRLF_EN
                            chr_d   = 2'd0;
`endif
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_START) begin
            tx_d = 1'b0;
        end else if (state_d == ST_DATA) begin
            tx_d = shift_d[0];
        end else begin
            tx_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
`ifdef HEX2ASCII_CRLF_EN
            chr_q     <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef HEX2ASCII_CRLF_EN
            chr_q     <= chr_d;
`endif
        end
    end

    assign oTx    = tx_q;
    assign oDone  = frame_end;
    assign oReady = (state_q == ST_IDLE) || frame_end;

endmodule

// File: tb/tb_hex2ascii_tx.sv
// Self-checking bench for hex2ascii_tx with a cycle-level line model.
// Honours HEX2ASCII_CRLF_EN to expect the CR/LF trailer frames.
module tb_hex2ascii_tx;

    localparam int CPB = 4;
`ifdef HEX2ASCII_CRLF_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 1;
`endif
    localparam int FLEN = NCH * 10 * CPB;

    logic       clk = 1'b0;
    logic       iRst = 1'b1;
    logic       iValid = 1'b0;
    logic [3:0] iDigit = 4'h0;
    logic       oReady;
    logic       oTx;
    logic       oDone;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    bit q[$];

    logic rec_tx[0:255];
    logic rec_rdy[0:255];
    int   done_at;
    int   n_done;

    hex2ascii_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk   (clk),
        .iRst  (iRst),
        .iDigit(iDigit),
        .iValid(iValid),
        .oReady(oReady),
        .oTx   (oTx),
        .oDone (oDone)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ascii_of(input logic [3:0] d);
        if (d < 4'd10) return 8'd48 + 8'(d);
        return 8'd65 + 8'(d) - 8'd10;
    endfunction

    task automatic push_char(input logic [7:0] c);
        logic [9:0] fr;
        fr = {1'b1, c, 1'b0};
        for (int b = 0; b < 10; b++)
            for (int k = 0; k < CPB; k++)
                q.push_back(fr[b]);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request queues the exact per-cycle line levels.
    always @(posedge clk) begin
        if (iRst) begin
            q.delete();
        end else if (iValid && q.size() == 0) begin
            push_char(ascii_of(iDigit));
`ifdef HEX2ASCII_CRLF_EN
            push_char(8'h0D);
            push_char(8'h0A);
`endif
        end
    end

    always @(negedge clk) begin
        logic etx, edone, erdy;
        if (chk_en) begin
            etx   = 1'b1;
            edone = 1'b0;
            if (q.size() > 0) begin
                etx   = q.pop_front();
                edone = (q.size() == 0);
            end
            erdy = (q.size() == 0);
            chk("tx", oTx, etx);
            chk("ready", oReady, erdy);
            chk("done", oDone, edone);
        end
    end

    // Called just after a negedge with the DUT idle.
    task automatic run_frame(input logic [3:0] d, input bit hold,
                             input int pulse_at, input int n);
        iDigit  = d;
        iValid  = 1'b1;
        done_at = 0;
        n_done  = 0;
        @(posedge clk);
        for (int s = 1; s <= n; s++) begin
            @(negedge clk);
            rec_tx[s]  = oTx;
            rec_rdy[s] = oReady;
            if (oDone) begin
                n_done++;
                if (done_at == 0) done_at = s;
            end
            if (!hold) iValid = (s == pulse_at);
            if (s == pulse_at) iDigit = 4'h3;
        end
        iValid = 1'b0;
    endtask

    function automatic logic [7:0] decode(input int base);
        logic [7:0] c;
        for (int k = 0; k < 8; k++)
            c[k] = rec_tx[base + CPB * (k + 1) + 2];
        return c;
    endfunction

    function automatic int ready_highs();
        int h;
        h = 0;
        for (int s = 1; s < FLEN; s++)
            h += int'(rec_rdy[s]);
        return h;
    endfunction

    initial begin
        iRst = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", oTx, 1);
        chk("rst_ready", oReady, 1);
        chk("rst_done", oDone, 0);
        iRst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_tx", oTx, 1);

        run_frame(4'h5, 1'b0, 0, FLEN + 2);
        chk("d5_start", rec_tx[1], 0);
        chk("d5_start_end", rec_tx[4], 0);
        chk("d5_bit0", rec_tx[5], 1);
        chk("d5_char", decode(0), 8'h35);
        chk("d5_stop", rec_tx[38], 1);
        chk("d5_done_at", done_at, FLEN);
        chk("d5_ndone", n_done, 1);
        chk("d5_busy", ready_highs(), 0);
`ifdef HEX2ASCII_CRLF_EN
        chk("crlf_cr", decode(40), 8'h0D);
        chk("crlf_lf", decode(80), 8'h0A);
        chk("crlf_cr_start", rec_tx[41], 0);
`endif
        chk("d5_idle_after", rec_tx[FLEN + 1], 1);

        run_frame(4'hA, 1'b1, 0, FLEN + 3);
        chk("dA_char", decode(0), 8'h41);
        chk("dA_done_at", done_at, FLEN);
        chk("dA_rdy_on_done", rec_rdy[FLEN], 1);
        chk("dA_no_gap_tx", rec_tx[FLEN + 1], 0);
        chk("dA_no_gap_rdy", rec_rdy[FLEN + 1], 0);
        repeat (FLEN + 4) @(negedge clk);

        run_frame(4'h7, 1'b0, 12, FLEN + 2);
        chk("pulse_char", decode(0), 8'h37);
        chk("pulse_ndone", n_done, 1);
        chk("pulse_idle_after", rec_tx[FLEN + 1], 1);
        chk("pulse_rdy_after", rec_rdy[FLEN + 2], 1);

        iDigit = 4'h9;
        iValid = 1'b1;
        @(negedge clk);
        iValid = 1'b0;
        repeat (14) @(negedge clk);
        iRst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_tx", oTx, 1);
        chk("abort_ready", oReady, 1);
        chk("abort_done", oDone, 0);
        @(negedge clk);
        iRst = 1'b0;
        @(negedge clk);
        run_frame(4'hF, 1'b0, 0, FLEN + 2);
        chk("dF_char", decode(0), 8'h46);
        chk("dF_start", rec_tx[2], 0);
        chk("dF_stop", rec_tx[38], 1);
        chk("dF_done_at", done_at, FLEN);

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            iValid = ($urandom_range(0, 3) == 0);
            iDigit = 4'($urandom);
            iRst   = ($urandom_range(0, 249) == 0);
        end
        @(negedge clk);
        iValid = 1'b0;
        iRst   = 1'b0;
        repeat (FLEN + 5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
